// File: rtl/if_id_buffer_pkg.sv
// Shared widths and constants for the fetch-to-decode instruction queue.
package if_id_buffer_pkg;

  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned INST_BUS_W      = 32;
  localparam int unsigned IFQ_DEPTH       = 4;

  // Bubble value presented to decode when the queue is empty (decodes as NOP).
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_id_buf_mem.sv
// Entry storage for the IF/ID queue: one write port, one asynchronous read port.
module if_id_buf_mem #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; occupancy tracking guards all reads.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/if_id_buffer.sv
// Fetch-to-decode instruction queue with valid/ready on both sides and branch flush.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_BUS_W,
  parameter int unsigned INST_W = INST_BUS_W,
  parameter int unsigned DEPTH  = IFQ_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready,
  input  logic              id_b_flag,
  input  logic              ex_b_flag,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned DATA_W = ADDR_W + INST_W;

  localparam logic [ADDR_W-1:0] BUBBLE_PC   = ADDR_W'(ZERO_WORD);
  localparam logic [INST_W-1:0] BUBBLE_INST = INST_W'(ZERO_WORD);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [PTR_W-1:0]  w_wr_ptr_nxt;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [CNT_W-1:0]  w_count_nxt;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd_data;
  logic [ADDR_W-1:0] w_rd_pc;
  logic [INST_W-1:0] w_rd_inst;

  // Full/empty are derived from occupancy so pointers can wrap freely.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  assign if_ready = !rst && !w_full;
  assign id_valid = !w_empty;
  assign count    = r_count;

  assign w_push  = if_valid && if_ready;
  assign w_pop   = id_valid && id_ready;
  assign w_flush = id_b_flag || ex_b_flag;
  assign w_wr_en = w_push && !w_flush;

  // Pointer/occupancy next state; a flush discards any same-cycle handshake.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  if_id_buf_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({if_pc, if_inst}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign {w_rd_pc, w_rd_inst} = w_rd_data;

  // Empty queue presents a bubble rather than stale storage.
  assign id_pc   = w_empty ? BUBBLE_PC   : w_rd_pc;
  assign id_inst = w_empty ? BUBBLE_INST : w_rd_inst;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed plus randomized checks of if_id_buffer against a queue-based reference model.
module tb_if_id_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
  logic        id_b_flag;
  logic        ex_b_flag;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc   [$];
  logic [31:0] m_inst [$];

  always #5 clk = ~clk;

  if_id_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_ready  (if_ready),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .id_ready  (id_ready),
    .id_b_flag (id_b_flag),
    .ex_b_flag (ex_b_flag),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's current queue contents.
  task automatic check_model();
    int sz;
    sz = m_pc.size();
    chk("if_ready", 64'(if_ready), 64'(!rst && sz != DEPTH));
    chk("id_valid", 64'(id_valid), 64'(sz != 0));
    chk("id_pc",    64'(id_pc),    (sz != 0) ? 64'(m_pc[0])   : 64'h0);
    chk("id_inst",  64'(id_inst),  (sz != 0) ? 64'(m_inst[0]) : 64'h0);
    chk("count",    64'(count),    64'(sz));
  endtask

  // Queue semantics at the clock edge: reset, then flush, then handshake.
  task automatic model_step();
    bit acc, take;
    if (rst || id_b_flag || ex_b_flag) begin
      m_pc.delete();
      m_inst.delete();
    end else begin
      acc  = if_valid && (m_pc.size() != DEPTH);
      take = id_ready && (m_pc.size() != 0);
      if (take) begin
        void'(m_pc.pop_front());
        void'(m_inst.pop_front());
      end
      if (acc) begin
        m_pc.push_back(if_pc);
        m_inst.push_back(if_inst);
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc, input logic rd,
                     input logic idb, input logic exb, input logic r);
    if_valid  = v;
    if_pc     = pc;
    if_inst   = pc ^ 32'hA5A5_0013;
    id_ready  = rd;
    id_b_flag = idb;
    ex_b_flag = exb;
    rst       = r;
    #1;
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b1; if_pc = '0; if_inst = '0;
    id_ready = 1'b0; id_b_flag = 1'b0; ex_b_flag = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset with if_valid asserted
    cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_if_ready", 64'(if_ready), 64'h0);
    chk("rst_count",    64'(count),    64'h0);
    rst = 1'b0; if_valid = 1'b0;
    #1;
    chk("post_rst_if_ready", 64'(if_ready), 64'h1);

    // 2: fill with decode stalled, then a rejected fifth push
    for (int k = 0; k < 4; k++) cyc(1'b1, 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'h4);
    chk("full_head",  64'(id_pc), 64'h0);
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_reject_count", 64'(count), 64'h4);

    // 3: drain in order
    for (int k = 0; k < 4; k++) begin
      if_valid = 1'b0; id_ready = 1'b1;
      #1;
      chk("drain_pc", 64'(id_pc), 64'(4 * k));
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("drained_valid", 64'(id_valid), 64'h0);
    chk("drained_inst",  64'(id_inst),  64'h0);

    // 4: streaming across pointer wrap
    for (int k = 0; k < 10; k++) cyc(1'b1, 32'h100 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stream_count", 64'(count), 64'h1);
    chk("stream_head",  64'(id_pc), 64'h124);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // 5: flush with a simultaneous push
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'h500 + 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(count), 64'h3);
    cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_count", 64'(count),    64'h0);
    chk("flush_valid", 64'(id_valid), 64'h0);
    cyc(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_flush_head", 64'(id_pc), 64'h300);

    // 6: flush with reset, then flush while empty
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_flush_count", 64'(count), 64'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("empty_flush_count", 64'(count), 64'h0);

    // Randomized traffic with occasional flushes and resets
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 24) == 0),
          1'($urandom_range(0, 60) == 0));
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
